// File: rtl/ps2_pkg.sv
// Shared types and register map for the PS/2 keyboard receiver.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [31:0] STATUS_OFS = 32'h0;
  localparam logic [31:0] DATA_OFS   = 32'h4;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_OVERFLOW   = 1;
  localparam int ST_PARITY_ERR = 2;
endpackage

// File: rtl/io_bus_interface.sv
// Simple memory-mapped IO bus; read_data is returned one cycle after read_en.
interface io_bus_interface;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave  (input read_en, write_en, address, write_data, output read_data);
  modport master (output read_en, write_en, address, write_data, input read_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; SIZE must be a power of two. A pop frees room for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(SIZE);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(SIZE));
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver with STATUS/DATA register window and a byte FIFO.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity and flag them in STATUS bit2.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h80,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            reset_n,
  io_bus_interface.slave  io_bus,
  input  logic            ps2_clk,
  input  logic            ps2_data
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_prev_q;
  logic        fall, din;
  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        push_q, push_d;
  logic        par_err_set;
  logic        ovf_q, ovf_d, perr_q, perr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_status, rd_data, pop, ovf_set;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_head;
  logic        unused_bus;

  assign din  = dat_sync_q[1];
  assign fall = clk_prev_q & ~clk_sync_q[1];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = '0;
    push_d      = 1'b0;
    par_err_set = 1'b0;
    // A stalled keyboard mid-frame must not wedge the receiver.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    if (fall) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = din;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din) begin
`ifdef PS2_PARITY_CHECK_EN
            if (^{shift_q, parity_q}) push_d = 1'b1;
            else                      par_err_set = 1'b1;
`else
            push_d = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rd_status = io_bus.read_en && (io_bus.address == BASE_ADDRESS + STATUS_OFS);
  assign rd_data   = io_bus.read_en && (io_bus.address == BASE_ADDRESS + DATA_OFS);
  assign pop       = rd_data & ~fifo_empty;
  assign ovf_set   = push_q & fifo_full & ~pop;

  always_comb begin
    rdata_d = '0;
    if (rd_status) begin
      rdata_d[ST_NOT_EMPTY]  = ~fifo_empty;
      rdata_d[ST_OVERFLOW]   = ovf_q;
      rdata_d[ST_PARITY_ERR] = perr_q;
    end else if (pop) begin
      rdata_d = {24'd0, fifo_head};
    end
    // Set events beat the clear-on-read of STATUS.
    ovf_d  = ovf_set | (ovf_q & ~rd_status);
    perr_d = par_err_set | (perr_q & ~rd_status);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      push_q     <= push_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign io_bus.read_data = rdata_q;
  assign unused_bus = ^{io_bus.write_en, io_bus.write_data, parity_q};

  // shift_q is stable during the push cycle: the next frame needs many edges to reach DATA.
  sync_fifo #(.WIDTH(8), .SIZE(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_q),
    .pop_i   (pop),
    .wdata_i (shift_q),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Parameter BASE_ADDRESS SHALL default to 'h80 and SHALL set the IO bus base address of the register window.
REQ-003 Parameter FIFO_DEPTH SHALL default to 8 and SHALL set the receive FIFO depth in bytes; it SHALL be a power of two and at least 2.
REQ-004 Parameter TIMEOUT_CYCLES SHALL default to 5000 and SHALL set the mid-frame ps2_clk idle limit in clk cycles (100 us at 50 MHz).
REQ-005 Port clk SHALL be a 1-bit input: the system clock.
REQ-006 Port reset_n SHALL be a 1-bit input: synchronous active-low reset.
REQ-007 Port io_bus SHALL be an io_bus_interface slave carrying read_en, write_en, address[31:0], write_data[31:0] and read_data[31:0].
REQ-008 Port ps2_clk SHALL be a 1-bit asynchronous input: the keyboard clock.
REQ-009 Port ps2_data SHALL be a 1-bit asynchronous input: the keyboard data.

Function
REQ-010 The block SHALL pass ps2_clk and ps2_data through two-flop synchronizers, and SHALL detect a falling edge as previous synchronized clock 1 and current 0.
REQ-011 The receive FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-012 In IDLE, on a falling edge with data 0 (start bit), the FSM SHALL go to DATA; with data 1 it SHALL stay in IDLE.
REQ-013 In DATA, the block SHALL shift in 8 bits LSB first on successive falling edges, using a 3-bit counter, then go to PARITY.
REQ-014 In PARITY, the block SHALL capture the parity bit on the falling edge and go to STOP.
REQ-015 In STOP, a falling edge with data 1 SHALL complete the frame; with data 0 the frame SHALL be discarded. Both cases SHALL return to IDLE.
REQ-016 A completed byte SHALL be pushed to the FIFO in the clk cycle after the stop-bit edge is detected, and SHALL be visible in the status register on the following cycle.
REQ-017 If no falling edge occurs for TIMEOUT_CYCLES consecutive clk cycles while not in IDLE, the FSM SHALL return to IDLE and discard the partial frame.
REQ-018 The register at BASE_ADDRESS+0 (STATUS, read-only) SHALL read as: bit0 FIFO not empty, bit1 overflow (sticky), bit2 parity error (sticky), bits 31:3 zero.
REQ-019 The register at BASE_ADDRESS+4 (DATA) SHALL read as {24'd0, head byte}, and a read SHALL pop the FIFO; a read when empty SHALL return 0 and SHALL not pop.
REQ-020 read_data SHALL be registered, valid the cycle after read_en, and SHALL be 0 for addresses outside the window.
REQ-021 A STATUS read SHALL clear the overflow and parity error bits after returning their values; a set event in the same cycle SHALL win, leaving the bit set.
REQ-022 A push into a full FIFO with no pop that cycle SHALL drop the byte and set overflow.
REQ-023 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full (no overflow) and when it is empty (the read returns 0 and the new byte is stored).
REQ-024 IO writes to the window SHALL be ignored.

Reset
REQ-025 While reset_n is 0 at a clk edge, the block SHALL set: FSM to IDLE, bit counter and timeout counter to 0, FIFO empty, sticky bits to 0, read_data to 0, and synchronizers to 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame, with no push occurring.

Configuration
REQ-027 With macro PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit do not have odd parity SHALL be discarded and SHALL set the parity error bit.
REQ-028 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored and STATUS bit2 SHALL read as 0.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state enum, the register offsets (STATUS 'h0, DATA 'h4) and the STATUS bit positions.
REQ-030 The FIFO SHALL be the existing sync_fifo sub-module, with WIDTH 8 and SIZE FIFO_DEPTH; the FSM and register logic SHALL stay in ps2_keyboard_rx.

Verification
REQ-031 The bench SHALL send a valid frame for byte 'h1C (parity 0) at a 10 kHz PS/2 clock -> STATUS reads 'h1, then DATA reads 'h1C, then STATUS reads 'h0.
REQ-032 The bench SHALL send 9 valid bytes 'h01..'h09 with no reads -> STATUS reads 'h3, DATA reads 'h01..'h08 in order, and the next STATUS reads 'h0.
REQ-033 With PS2_PARITY_CHECK_EN, the bench SHALL send 'h1C with parity 1 -> STATUS reads 'h4 and the FIFO stays empty; without the macro, STATUS reads 'h1 and DATA reads 'h1C.
REQ-034 The bench SHALL send a start bit plus 4 data bits and then hold ps2_clk high for 5000 cycles, followed by a valid 'hF0 frame -> DATA reads 'hF0 only.
REQ-035 The bench SHALL send a frame with stop bit 0 -> no push and STATUS reads 'h0.
REQ-036 The bench SHALL pulse reset_n low for one cycle after the 5th data bit of a frame -> STATUS reads 'h0, and the next valid 'hAA frame reads back 'hAA.
